// File: rtl/cpu_datapath_gen2.sv
// rtl/cpu_datapath_gen2.sv - multicycle CPU datapath with a three-state memory access sequencer
// Optional feature macro: DP_CV_FLAGS_EN (adds carry/overflow flags; without it o_c/o_v tie to 0)
module cpu_datapath_gen2 #(
  parameter int          DATA_W   = 16,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned LINK_REG = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_mem_req,
  input  logic              i_mem_we,
  input  logic              i_addr_sel,
  input  logic              i_dst_ir,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rddata,
  input  logic              i_pc_write,
  input  logic              i_opa_sel,
  input  logic              i_opab_load,
  input  logic [1:0]        i_alu_a_sel,
  input  logic [1:0]        i_alu_b_sel,
  input  logic [1:0]        i_alu_op,
  input  logic              i_alu_load,
  input  logic              i_mov_hi,
  input  logic              i_rf_write,
  input  logic              i_rf_write_call,
  input  logic              i_reg_in,
  input  logic              i_flag_write,
  output logic [DATA_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wrdata,
  output logic              o_mem_rd,
  output logic              o_mem_wr,
  output logic              o_mem_busy,
  output logic              o_mem_done,
  output logic [4:0]        o_opcode,
  output logic              o_imm,
  output logic              o_n,
  output logic              o_z,
  output logic              o_c,
  output logic              o_v
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } mem_state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  // Memory sequencer state and the access parameters frozen at request time
  mem_state_t        state_q, state_d;
  logic              mem_start;
  logic              mem_finish;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wrdata_q;
  logic              we_q;
  logic              dst_ir_q;

  // Architectural and staging registers
  logic [DATA_W-1:0] pc_q;
  logic [15:0]       ir_q;
  logic [DATA_W-1:0] mdr_q;
  logic [DATA_W-1:0] opa_q;
  logic [DATA_W-1:0] opb_q;
  logic [DATA_W-1:0] alu_out_q;
  logic [DATA_W-1:0] rf_q [0:7];
  logic              n_q, z_q;

  // Register file ports
  logic [2:0]        rf_a_idx, rf_b_idx, rf_w_idx;
  logic [DATA_W-1:0] rf_a_data, rf_b_data, rf_w_data;

  // ALU operands and results
  logic [DATA_W-1:0] imm8_sext;
  logic [DATA_W-1:0] imm11_sh;
  logic [DATA_W-1:0] alu_a, alu_b, alu_res;
  logic [DATA_W-1:0] mov_hi_val;
  logic              alu_c, alu_v;

  // Sequencer state register; reset aborts any access in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Sequencer next state and strobes; req only counts in IDLE, ack only in ACCESS
  always_comb begin
    state_d    = state_q;
    mem_start  = 1'b0;
    mem_finish = 1'b0;
    o_mem_rd   = 1'b0;
    o_mem_wr   = 1'b0;
    o_mem_busy = 1'b0;
    o_mem_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_mem_req) begin
          state_d   = ST_ACCESS;
          mem_start = 1'b1;
        end
      end
      ST_ACCESS: begin
        o_mem_busy = 1'b1;
        o_mem_rd   = ~we_q;
        o_mem_wr   = we_q;
        if (i_mem_ack) begin
          state_d    = ST_DONE;
          mem_finish = 1'b1;
        end
      end
      ST_DONE: begin
        o_mem_done = 1'b1;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Freeze address, write data and direction when an access starts so later
  // PC/opA/opB updates cannot disturb the bus mid-access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      wrdata_q <= '0;
      we_q     <= 1'b0;
      dst_ir_q <= 1'b0;
    end else if (mem_start) begin
      addr_q   <= i_addr_sel ? pc_q : opb_q;
      wrdata_q <= opa_q;
      we_q     <= i_mem_we;
      dst_ir_q <= i_dst_ir;
    end
  end

  assign o_mem_addr   = addr_q;
  assign o_mem_wrdata = wrdata_q;

  // Capture read data on the acknowledging edge into IR (low 16 bits) or MDR
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_q  <= '0;
      mdr_q <= '0;
    end else if (mem_finish && !we_q) begin
      if (dst_ir_q) begin
        ir_q <= i_mem_rddata[15:0];
      end else begin
        mdr_q <= i_mem_rddata;
      end
    end
  end

  assign o_opcode = ir_q[4:0];
  assign o_imm    = ir_q[4];

  // Register file read/write index and data selection
  always_comb begin
    rf_a_idx  = i_opa_sel ? 3'd1 : ir_q[7:5];
    rf_b_idx  = ir_q[10:8];
    rf_w_idx  = i_rf_write_call ? 3'(LINK_REG) : ir_q[7:5];
    rf_a_data = rf_q[rf_a_idx];
    rf_b_data = rf_q[rf_b_idx];
    rf_w_data = i_reg_in ? mdr_q : alu_out_q;
  end

  // Register file write port; a same-cycle read still sees the old contents
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        rf_q[i] <= '0;
      end
    end else if (i_rf_write) begin
      rf_q[rf_w_idx] <= rf_w_data;
    end
  end

  // Operand latches fed from the register file read ports
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa_q <= '0;
      opb_q <= '0;
    end else if (i_opab_load) begin
      opa_q <= rf_a_data;
      opb_q <= rf_b_data;
    end
  end

  // Immediate decode and ALU operand muxes
  always_comb begin
    imm8_sext = {{(DATA_W-8){ir_q[15]}}, ir_q[15:8]};
    imm11_sh  = {{(DATA_W-12){ir_q[15]}}, ir_q[15:5], 1'b0};
    case (i_alu_a_sel)
      2'b00:   alu_a = pc_q;
      2'b01:   alu_a = opa_q;
      default: alu_a = '0;
    endcase
    case (i_alu_b_sel)
      2'b00:   alu_b = opb_q;
      2'b01:   alu_b = DATA_W'(2);
      2'b10:   alu_b = imm8_sext;
      default: alu_b = imm11_sh;
    endcase
  end

`ifdef DP_CV_FLAGS_EN
  logic [DATA_W:0]   sum_ext;
  logic [DATA_W-1:0] b_eff;
  logic              is_sub;

  // ALU with a shared add/subtract carry chain; SUB is A + ~B + 1 so the
  // carry-out reads as "no borrow"
  always_comb begin
    is_sub  = (i_alu_op == OP_SUB);
    b_eff   = is_sub ? ~alu_b : alu_b;
    sum_ext = {1'b0, alu_a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, is_sub};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (i_alu_op)
      OP_ADD, OP_SUB: begin
        alu_res = sum_ext[DATA_W-1:0];
        alu_c   = sum_ext[DATA_W];
        alu_v   = (alu_a[DATA_W-1] == b_eff[DATA_W-1]) &&
                  (alu_res[DATA_W-1] != alu_a[DATA_W-1]);
      end
      OP_AND:  alu_res = alu_a & alu_b;
      default: alu_res = alu_a | alu_b;
    endcase
  end
`else
  // ALU without carry/overflow generation
  always_comb begin
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (i_alu_op)
      OP_ADD:  alu_res = alu_a + alu_b;
      OP_SUB:  alu_res = alu_a - alu_b;
      OP_AND:  alu_res = alu_a & alu_b;
      default: alu_res = alu_a | alu_b;
    endcase
  end
`endif

  // Mov-hi: replace byte [15:8] of opA with imm8, keep everything else
  always_comb begin
    mov_hi_val        = opa_q;
    mov_hi_val[15:8]  = ir_q[15:8];
  end

  // ALU output register; mov-hi only matters when the register is loaded
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_out_q <= '0;
    end else if (i_alu_load) begin
      alu_out_q <= i_mov_hi ? mov_hi_val : alu_res;
    end
  end

  // Program counter, loaded straight from the combinational ALU result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= DATA_W'(RESET_PC);
    end else if (i_pc_write) begin
      pc_q <= alu_res;
    end
  end

  // Negative and zero flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q <= 1'b0;
      z_q <= 1'b0;
    end else if (i_flag_write) begin
      n_q <= alu_res[DATA_W-1];
      z_q <= (alu_res == '0);
    end
  end

  assign o_n = n_q;
  assign o_z = z_q;

`ifdef DP_CV_FLAGS_EN
  logic c_q, v_q;

  // Carry and overflow flags; logical ops clear both
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q <= 1'b0;
      v_q <= 1'b0;
    end else if (i_flag_write) begin
      c_q <= alu_c;
      v_q <= alu_v;
    end
  end

  assign o_c = c_q;
  assign o_v = v_q;
`else
  logic unused_cv;
  assign unused_cv = alu_c | alu_v;
  assign o_c = 1'b0;
  assign o_v = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_datapath_gen2.sv
// tb/tb_cpu_datapath_gen2.sv - directed bench for cpu_datapath_gen2 (16-bit and 32-bit instances)
module tb_cpu_datapath_gen2;

`ifdef DP_CV_FLAGS_EN
  localparam logic CV = 1'b1;
`else
  localparam logic CV = 1'b0;
`endif

  logic clk, rst;
  logic mem_req, mem_we, addr_sel, dst_ir, mem_ack, pc_write, opa_sel, opab_load;
  logic alu_load, mov_hi, rf_write, rf_write_call, reg_in, flag_write;
  logic [1:0] alu_a_sel, alu_b_sel, alu_op;
  logic [15:0] rdata16;
  logic [31:0] rdata32;

  logic [15:0] addr16, wdata16;
  logic        rd16, wr16, busy16, done16, imm16, n16, z16, c16, v16;
  logic [4:0]  opc16;
  logic [31:0] addr32, wdata32;
  logic        rd32, wr32, busy32, done32, imm32, n32, z32, c32, v32;
  logic [4:0]  opc32;

  logic [15:0] cap_a16, cap_wd16;
  logic [31:0] cap_a32, cap_wd32;
  logic        cap_rd, cap_wr;

  int n_cmp;
  int n_bad;

  cpu_datapath_gen2 #(.DATA_W(16), .RESET_PC('h0010), .LINK_REG(7)) u16 (
    .clk(clk), .rst(rst),
    .i_mem_req(mem_req), .i_mem_we(mem_we), .i_addr_sel(addr_sel), .i_dst_ir(dst_ir),
    .i_mem_ack(mem_ack), .i_mem_rddata(rdata16), .i_pc_write(pc_write), .i_opa_sel(opa_sel),
    .i_opab_load(opab_load), .i_alu_a_sel(alu_a_sel), .i_alu_b_sel(alu_b_sel), .i_alu_op(alu_op),
    .i_alu_load(alu_load), .i_mov_hi(mov_hi), .i_rf_write(rf_write), .i_rf_write_call(rf_write_call),
    .i_reg_in(reg_in), .i_flag_write(flag_write),
    .o_mem_addr(addr16), .o_mem_wrdata(wdata16), .o_mem_rd(rd16), .o_mem_wr(wr16),
    .o_mem_busy(busy16), .o_mem_done(done16), .o_opcode(opc16), .o_imm(imm16),
    .o_n(n16), .o_z(z16), .o_c(c16), .o_v(v16)
  );

  cpu_datapath_gen2 #(.DATA_W(32), .RESET_PC('h0010), .LINK_REG(7)) u32 (
    .clk(clk), .rst(rst),
    .i_mem_req(mem_req), .i_mem_we(mem_we), .i_addr_sel(addr_sel), .i_dst_ir(dst_ir),
    .i_mem_ack(mem_ack), .i_mem_rddata(rdata32), .i_pc_write(pc_write), .i_opa_sel(opa_sel),
    .i_opab_load(opab_load), .i_alu_a_sel(alu_a_sel), .i_alu_b_sel(alu_b_sel), .i_alu_op(alu_op),
    .i_alu_load(alu_load), .i_mov_hi(mov_hi), .i_rf_write(rf_write), .i_rf_write_call(rf_write_call),
    .i_reg_in(reg_in), .i_flag_write(flag_write),
    .o_mem_addr(addr32), .o_mem_wrdata(wdata32), .o_mem_rd(rd32), .o_mem_wr(wr32),
    .o_mem_busy(busy32), .o_mem_done(done32), .o_opcode(opc32), .o_imm(imm32),
    .o_n(n32), .o_z(z32), .o_c(c32), .o_v(v32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ctl_clear();
    mem_req = 0; mem_we = 0; addr_sel = 0; dst_ir = 0; mem_ack = 0;
    pc_write = 0; opa_sel = 0; opab_load = 0; alu_load = 0; mov_hi = 0;
    rf_write = 0; rf_write_call = 0; reg_in = 0; flag_write = 0;
    alu_a_sel = 2'b00; alu_b_sel = 2'b00; alu_op = 2'b00;
  endtask

  // One-cycle access: request, ack in the first ACCESS cycle, back to IDLE
  task automatic mem_op(input logic we, input logic asel, input logic dir,
                        input logic [15:0] d16, input logic [31:0] d32);
    ctl_clear();
    mem_req = 1; mem_we = we; addr_sel = asel; dst_ir = dir;
    step();
    mem_req = 0;
    cap_a16 = addr16; cap_wd16 = wdata16; cap_a32 = addr32; cap_wd32 = wdata32;
    cap_rd = rd16; cap_wr = wr16;
    mem_ack = 1; rdata16 = d16; rdata32 = d32;
    step();
    mem_ack = 0;
    step();
    ctl_clear();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    ctl_clear();
    rdata16 = '0;
    rdata32 = '0;
    rst = 1;
    repeat (2) step();
    chk("rst_strobes16", {rd16, wr16, busy16, done16}, 0);
    chk("rst_opcode16", {imm16, opc16}, 0);
    chk("rst_flags16", {n16, z16, c16, v16}, 0);
    chk("rst_out32", {rd32, wr32, busy32, done32, opc32, imm32, n32, z32, c32, v32}, 0);
    rst = 0;
    step();

    // Fetch from PC=0x0010 with ack in the third ACCESS cycle
    mem_req = 1; addr_sel = 1; dst_ir = 1;
    step();
    mem_req = 0;
    chk("fetch_addr", addr16, 16'h0010);
    chk("fetch_rd_c1", rd16, 1);
    chk("fetch_busy_c1", busy16, 1);
    chk("fetch_no_wr", wr16, 0);
    step();
    chk("fetch_rd_c2", rd16, 1);
    step();
    chk("fetch_rd_c3", rd16, 1);
    chk("fetch_nodone_c3", done16, 0);
    mem_ack = 1; rdata16 = 16'h1234; rdata32 = 32'h0000_1234;
    step();
    mem_ack = 0;
    chk("fetch_rd_off", rd16, 0);
    chk("fetch_done", done16, 1);
    chk("fetch_opcode", opc16, 5'h14);
    chk("fetch_imm", imm16, 1);
    step();
    chk("done_one_cycle", done16, 0);
    chk("idle_busy", busy16, 0);

    // Ack while idle must not start anything
    mem_ack = 1;
    step();
    mem_ack = 0;
    chk("ack_idle_busy", busy16, 0);
    chk("ack_idle_done", done16, 0);

    // MDR=0x0100 -> r1 -> opA; PC = opA + opB(r2=0)
    mem_op(0, 0, 0, 16'h0100, 32'h0000_0100);
    chk("addr_from_opb", cap_a16, 16'h0000);
    rf_write = 1; reg_in = 1; step(); ctl_clear();
    opab_load = 1; step(); ctl_clear();
    alu_a_sel = 2'b01; pc_write = 1; flag_write = 1; step(); ctl_clear();
    mem_op(0, 1, 1, 16'hFFE0, 32'h0000_FFE0);
    chk("pc_from_alu", cap_a16, 16'h0100);
    chk("opcode_ffe0", opc16, 5'h00);

    // PC = PC + (imm11 << 1) with imm11 = -1
    alu_b_sel = 2'b11; pc_write = 1; flag_write = 1; step(); ctl_clear();
    chk("imm11_carry", c16, CV);
    chk("imm11_neg", n16, 0);

    // Second req and pc_write during ACCESS leave the bus untouched
    mem_req = 1; addr_sel = 1;
    step();
    chk("branch_pc_addr", addr16, 16'h00FE);
    addr_sel = 0; alu_a_sel = 2'b10; alu_b_sel = 2'b01; pc_write = 1;
    step();
    ctl_clear();
    chk("addr_held", addr16, 16'h00FE);
    chk("busy_held", busy16, 1);
    mem_ack = 1; rdata16 = 16'h7FFF; rdata32 = 32'h0000_7FFF;
    step();
    mem_ack = 0;
    chk("done_after_ack", done16, 1);
    step();
    chk("second_req_ignored", busy16, 0);

    // IR=0x0731 at PC=2: r1 = 0x7FFF, r7 = 1 via call path, ADD 0x7FFF+1
    mem_op(0, 1, 1, 16'h0731, 32'h0000_0731);
    chk("pc_after_mid_write", cap_a16, 16'h0002);
    chk("opcode_0731", opc16, 5'h11);
    chk("imm_0731", imm16, 1);
    rf_write = 1; reg_in = 1; step(); ctl_clear();
    mem_op(0, 0, 0, 16'h0001, 32'h0000_0001);
    rf_write = 1; reg_in = 1; rf_write_call = 1; step(); ctl_clear();
    opab_load = 1; opa_sel = 1; step(); ctl_clear();
    alu_a_sel = 2'b01; flag_write = 1; step(); ctl_clear();
    chk("add_n", n16, 1);
    chk("add_z", z16, 0);
    chk("add_c", c16, 0);
    chk("add_v", v16, CV);
    mem_op(1, 0, 0, 16'h0000, 32'h0000_0000);
    chk("wr_data_opa", cap_wd16, 16'h7FFF);
    chk("wr_addr_opb", cap_a16, 16'h0001);
    chk("wr_strobe", cap_wr, 1);
    chk("wr_no_rd", cap_rd, 0);

    // SUB 0x7FFF-1 then AND 0 & opB
    alu_a_sel = 2'b01; alu_op = 2'b01; flag_write = 1; step(); ctl_clear();
    chk("sub_n", n16, 0);
    chk("sub_c", c16, CV);
    chk("sub_v", v16, 0);
    alu_a_sel = 2'b10; alu_op = 2'b10; flag_write = 1; step(); ctl_clear();
    chk("and_z", z16, 1);
    chk("and_cv_clear", {c16, v16}, 0);

    // Call writes ALU_out (0x42 from imm8) to r7, r1 untouched
    mem_op(0, 1, 1, 16'h4231, 32'h0000_4231);
    alu_a_sel = 2'b10; alu_b_sel = 2'b10; alu_load = 1; step(); ctl_clear();
    rf_write = 1; rf_write_call = 1; step(); ctl_clear();
    mem_op(0, 1, 1, 16'h0731, 32'h0000_0731);
    opab_load = 1; opa_sel = 1; step(); ctl_clear();
    mem_op(1, 0, 0, 16'h0000, 32'h0000_0000);
    chk("call_r7", cap_a16, 16'h0042);
    chk("call_r1_kept", cap_wd16, 16'h7FFF);

    // Mov-hi with imm8=0x12 on opA=0xAABBCCDD (32-bit) / 0xCCDD (16-bit)
    mem_op(0, 1, 1, 16'h1231, 32'h0000_1231);
    mem_op(0, 0, 0, 16'hCCDD, 32'hAABB_CCDD);
    rf_write = 1; reg_in = 1; step(); ctl_clear();
    opab_load = 1; opa_sel = 1; step(); ctl_clear();
    mov_hi = 1; step(); ctl_clear();
    rf_write = 1; rf_write_call = 1; step(); ctl_clear();
    alu_load = 1; mov_hi = 1; step(); ctl_clear();
    rf_write = 1; step(); ctl_clear();
    mem_op(0, 1, 1, 16'h0731, 32'h0000_0731);
    opab_load = 1; opa_sel = 1; step(); ctl_clear();
    mem_op(1, 0, 0, 16'h0000, 32'h0000_0000);
    chk("movhi32", cap_wd32, 32'hAABB_12DD);
    chk("movhi16", cap_wd16, 16'h12DD);
    chk("movhi_noload16", cap_a16, 16'h0042);
    chk("movhi_noload32", cap_a32, 32'h0000_0042);

    // Reset in the middle of a read aborts it
    mem_req = 1; addr_sel = 1; dst_ir = 1;
    step();
    mem_req = 0;
    chk("pre_rst_rd", rd16, 1);
    #2;
    rst = 1;
    #1;
    chk("rst_rd_async", rd16, 0);
    chk("rst_busy_async", busy16, 0);
    mem_ack = 1; rdata16 = 16'hBEEF; rdata32 = 32'h0000_BEEF;
    step();
    mem_ack = 0;
    chk("rst_ir_opcode", {imm16, opc16}, 0);
    chk("rst_done", done16, 0);
    rst = 0;
    step();
    mem_op(0, 1, 1, 16'h0000, 32'h0000_0000);
    chk("rst_pc", cap_a16, 16'h0010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_datapath_gen2.md
CPU_DATAPATH_GEN2 -- requirements
Module: cpu_datapath_gen2

Interface
REQ-001 Parameter DATA_W, default 16, meaning datapath/register width; legal values 16 or 32.
REQ-002 Parameter RESET_PC, default 0, meaning PC value after reset.
REQ-003 Parameter LINK_REG, default 7, meaning register index written on call.
REQ-004 The block SHALL use reset rst, asynchronous, active-high, and clock clk; clk SHALL be the sole clock.
REQ-005 Ports SHALL be, in order:
- clk  in  1  clock
- rst  in  1  async active-high reset
- i_mem_req  in  1  start memory access (pulse)
- i_mem_we  in  1  access is write (1) or read (0), sampled with i_mem_req
- i_addr_sel  in  1  access address: PC (1) or opB (0), sampled with i_mem_req
- i_dst_ir  in  1  read data destination: IR (1) or MDR (0), sampled with i_mem_req
- i_mem_ack  in  1  memory completion
- i_mem_rddata  in  DATA_W  memory read data
- i_pc_write  in  1  load PC from ALU result
- i_opa_sel  in  1  opA register index: 1 (1) or IR[7:5] (0)
- i_opab_load  in  1  load opA/opB from register file
- i_alu_a_sel  in  2  ALU A: 00 PC, 01 opA, others zero
- i_alu_b_sel  in  2  ALU B: 00 opB, 01 const 2, 10 sext imm8, 11 sext imm11<<1
- i_alu_op  in  2  00 ADD, 01 SUB, 10 AND, 11 OR
- i_alu_load  in  1  load ALU_out register
- i_mov_hi  in  1  ALU_out register takes mov-hi value
- i_rf_write  in  1  register file write enable
- i_rf_write_call  in  1  write index LINK_REG instead of IR[7:5]
- i_reg_in  in  1  write data MDR (1) or ALU_out register (0)
- i_flag_write  in  1  update flags
- o_mem_addr  out  DATA_W  access address
- o_mem_wrdata  out  DATA_W  write data
- o_mem_rd  out  1  read strobe
- o_mem_wr  out  1  write strobe
- o_mem_busy  out  1  access in progress
- o_mem_done  out  1  one-cycle completion pulse
- o_opcode  out  5  IR[4:0]
- o_imm  out  1  IR[4]
- o_n, o_z  out  1  negative, zero flags
- o_c, o_v  out  1  carry, overflow flags (see Configuration)

Function
REQ-006 Memory FSM states IDLE, ACCESS, DONE; IDLE->ACCESS on i_mem_req; ACCESS->DONE on i_mem_ack; DONE->IDLE unconditionally.
REQ-007 On IDLE->ACCESS, address (per i_addr_sel), write data (opA), direction and destination SHALL be latched; o_mem_addr/o_mem_wrdata SHALL hold latched values throughout ACCESS.
REQ-008 o_mem_rd (read) or o_mem_wr (write) and o_mem_busy SHALL be high exactly while in ACCESS; minimum access length one cycle (ack in first ACCESS cycle).
REQ-009 On ack of a read, i_mem_rddata[15:0] SHALL load IR (i_dst_ir=1) or full i_mem_rddata load MDR, at that clock edge.
REQ-010 o_mem_done SHALL be high only in DONE; i_mem_req outside IDLE SHALL be ignored; i_mem_ack outside ACCESS SHALL be ignored.
REQ-011 PC, opA/opB, flags, register file SHALL update independently of memory FSM; i_pc_write during ACCESS SHALL NOT alter latched address.
REQ-012 imm8 = IR[15:8], imm11 = IR[15:5]; both sign-extended to DATA_W; imm11 shifted left one.
REQ-013 Register file 8 x DATA_W, two combinational read ports (A index per i_opa_sel, B index IR[10:8]), one synchronous write port; write and read of same register in one cycle returns old value.
REQ-014 ALU arithmetic modulo 2^DATA_W; N = result MSB, Z = result all zero, registered only when i_flag_write.
REQ-015 Mov-hi value: bits[15:8] = imm8, bits[7:0] = opA[7:0], bits above 15 = opA upper bits; i_mov_hi without i_alu_load SHALL have no effect.

Reset
REQ-016 rst SHALL asynchronously set PC=RESET_PC; IR, MDR, opA, opB, ALU_out register, all registers, flags to 0; FSM to IDLE; o_mem_rd/wr/busy/done to 0.
REQ-017 Reset during ACCESS SHALL abort the access with no IR/MDR update.

Configuration
REQ-018 Macro DP_CV_FLAGS_EN defined: o_c = ADD carry-out / SUB no-borrow, o_v = signed overflow, for ADD/SUB, cleared for AND/OR, updated with i_flag_write.
REQ-019 Macro undefined: o_c and o_v SHALL be constant 0 and no carry/overflow logic SHALL be built.

Verification
REQ-020 DATA_W=16, PC=0x0010, fetch req addr_sel=1 dst_ir=1, ack after 3 cycles with data 0x1234 -> rd high 3 cycles, IR=0x1234, done one cycle.
REQ-021 opA=0x7FFF, opB=0x0001, ADD, flag_write -> N=1, Z=0, V=1 and C=0 with DP_CV_FLAGS_EN; C=V=0 without.
REQ-022 IR[15:5]=0x7FF (imm11=-1), alu_b_sel=11, A=PC=0x0100, pc_write -> PC=0x00FE.
REQ-023 i_mem_req during ACCESS, plus pc_write mid-access -> second req ignored, o_mem_addr unchanged.
REQ-024 Call: i_rf_write_call=1, ALU_out reg=0x0042, rf_write -> r7=0x0042, IR[7:5] register unchanged.
REQ-025 rst asserted mid-read -> strobes low same cycle, IR retains 0, PC=RESET_PC; DATA_W=32 mov-hi opA=0xAABBCCDD imm8=0x12 -> 0xAABB12DD.
